sopc4_tick_clock: RTL and testbench

Avalon-MM slave that consumes the interval timer's `irq` as a tick source. It prescales ticks into seconds, keeps a BCD mm:ss time-of-run counter with a programmable alarm, and raises its own interrupt to the CPU on alarm match. It sits directly downstream of the interval timer in the sopc4 system and shares its 16-bit register bus.

---
 rtl/sopc4_tick_clock.sv | 199 +++++++++++++++++++
 tb/tb_sopc4_tick_clock.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sopc4_tick_clock.sv
// Tick-driven mm:ss run clock with prescaler, BCD alarm and CPU interrupt.
// Consumes the interval timer irq level as its tick source over a 16-bit Avalon-MM slave.
module sopc4_tick_clock #(
  parameter logic [15:0] RESET_PRESCALE = 16'h0000,
  parameter logic [15:0] RESET_ALARM    = 16'h0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  input  logic        tick_in,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int DATA_W = 16;

  localparam logic [2:0] A_STATUS   = 3'd0;
  localparam logic [2:0] A_CONTROL  = 3'd1;
  localparam logic [2:0] A_TICKS    = 3'd2;
  localparam logic [2:0] A_TIME     = 3'd3;
  localparam logic [2:0] A_ALARM    = 3'd4;
  localparam logic [2:0] A_PRESCALE = 3'd5;

  logic              tick_d;
  logic              irq_enable;
  logic              run;
  logic              stop_on_alarm;
  logic              alarm_occurred;
  logic              overflow;
  logic [DATA_W-1:0] ticks;
  logic [DATA_W-1:0] mmss;
  logic [DATA_W-1:0] alarm;
  logic [DATA_W-1:0] prescale;
  logic [DATA_W-1:0] pcount;

  logic              wr_en;
  logic              wr_status;
  logic              wr_ctrl;
  logic              wr_ticks;
  logic              wr_time;
  logic              wr_alarm;
  logic              wr_prescale;
  logic              clear_stb;
  logic              running;
  logic              tick_event;
  logic              pcount_hit;
  logic              sec_adv;
  logic              alarm_hit;
  logic              overflow_hit;
  logic [DATA_W-1:0] next_mmss;
  logic              wrap;
  logic [4:0]        u_s;
  logic [4:0]        t_s;
  logic [4:0]        u_m;
  logic [4:0]        t_m;
  logic [DATA_W-1:0] rd_next;

  // One BCD digit step: {carry_out, digit}. A digit at or above its limit
  // wraps to zero, so out-of-range values written by software self-correct.
  function automatic logic [4:0] bcd_step(input logic [3:0] d,
                                          input logic [3:0] lim,
                                          input logic       cin);
    if (!cin)
      return {1'b0, d};
    else if (d >= lim)
      return {1'b1, 4'd0};
    else
      return {1'b0, d + 4'd1};
  endfunction

  assign wr_en       = chipselect && !write_n;
  assign wr_status   = wr_en && (address == A_STATUS);
  assign wr_ctrl     = wr_en && (address == A_CONTROL);
  assign wr_ticks    = wr_en && (address == A_TICKS);
  assign wr_time     = wr_en && (address == A_TIME);
  assign wr_alarm    = wr_en && (address == A_ALARM);
  assign wr_prescale = wr_en && (address == A_PRESCALE);
  assign clear_stb   = wr_ctrl && writedata[2];

  assign running    = run;
  assign tick_event = tick_in && !tick_d && running;
  assign pcount_hit = (pcount == prescale);

  always_comb begin
    u_s       = bcd_step(mmss[3:0],   4'd9, 1'b1);
    t_s       = bcd_step(mmss[7:4],   4'd5, u_s[4]);
    u_m       = bcd_step(mmss[11:8],  4'd9, t_s[4]);
    t_m       = bcd_step(mmss[15:12], 4'd5, u_m[4]);
    next_mmss = {t_m[3:0], u_m[3:0], t_s[3:0], u_s[3:0]};
    wrap      = t_m[4];
  end

  // A second advance only lands when neither clear nor a TIME write overrides it,
  // so alarm and overflow are judged on the value that is actually stored.
  assign sec_adv      = tick_event && pcount_hit && !clear_stb && !wr_time;
  assign alarm_hit    = sec_adv && (next_mmss == alarm);
  assign overflow_hit = sec_adv && wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_d        <= 1'b0;
      irq_enable    <= 1'b0;
      run           <= 1'b0;
      stop_on_alarm <= 1'b0;
    end else begin
      tick_d <= tick_in;
      if (wr_ctrl) begin
        irq_enable    <= writedata[0];
        run           <= writedata[1];
        stop_on_alarm <= writedata[3];
      end else if (alarm_hit && stop_on_alarm) begin
        run <= 1'b0;
      end
    end
  end

  // Status events take precedence over a software clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_occurred <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (alarm_hit)
        alarm_occurred <= 1'b1;
      else if (wr_status)
        alarm_occurred <= 1'b0;
      if (overflow_hit)
        overflow <= 1'b1;
      else if (wr_status)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ticks  <= '0;
      mmss   <= '0;
      pcount <= '0;
    end else begin
      if (clear_stb)
        ticks <= '0;
      else if (wr_ticks)
        ticks <= writedata;
      else if (tick_event)
        ticks <= ticks + 16'd1;

      if (clear_stb)
        mmss <= '0;
      else if (wr_time)
        mmss <= writedata;
      else if (sec_adv)
        mmss <= next_mmss;

      if (clear_stb || wr_prescale)
        pcount <= '0;
      else if (tick_event)
        pcount <= pcount_hit ? '0 : pcount + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm    <= RESET_ALARM;
      prescale <= RESET_PRESCALE;
    end else begin
      if (wr_alarm)
        alarm <= writedata;
      if (wr_prescale)
        prescale <= writedata;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      A_STATUS:   rd_next = {13'd0, overflow, running, alarm_occurred};
      A_CONTROL:  rd_next = {12'd0, stop_on_alarm, 1'b0, run, irq_enable};
      A_TICKS:    rd_next = ticks;
      A_TIME:     rd_next = mmss;
      A_ALARM:    rd_next = alarm;
      A_PRESCALE: rd_next = prescale;
      default:    rd_next = '0;
    endcase
  end

  // Read data is registered every cycle, independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else
      readdata <= rd_next;
  end

  assign irq = alarm_occurred && irq_enable;

endmodule

// File: tb/tb_sopc4_tick_clock.sv
// Directed bench for sopc4_tick_clock: register access, prescaling, BCD carry,
// alarm/stop behaviour, clear/write priority and asynchronous reset.
module tb_sopc4_tick_clock;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic        tick_in;
  logic [15:0] readdata;
  logic        irq;

  int checks;
  int passes;
  logic [15:0] rd;

  sopc4_tick_clock dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .tick_in    (tick_in),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All bus/tick tasks start and end on a falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    tick_in = 1'b1;
    repeat (hi) @(negedge clk);
    tick_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] exp_regs [0:5];
    exp_regs = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      bus_read(3'(i), rd);
      checks++;
      if (rd !== exp_regs[i]) $display("FAIL reset_reg%0d got %h want %h", i, rd, exp_regs[i]);
      else passes++;
    end
    checks++;
    if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq);
    else passes++;
    bus_write(3'd6, 16'hBEEF);
    bus_read(3'd6, rd);
    checks++;
    if (rd !== 16'h0000) $display("FAIL reg6_read got %h want 0000", rd);
    else passes++;
  endtask

  task automatic test_count();
    bus_write(3'd1, 16'h0003);
    repeat (5) pulse(3, 2);
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 16'd5) $display("FAIL count_ticks got %h want 0005", rd);
    else passes++;
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 16'h0005) $display("FAIL count_time got %h want 0005", rd);
    else passes++;
    pulse(20, 2);
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 16'd6) $display("FAIL held_level_ticks got %h want 0006", rd);
    else passes++;
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0002) $display("FAIL status_running got %h want 0002", rd);
    else passes++;
  endtask

  task automatic test_prescale();
    bus_write(3'd1, 16'h0007);
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 16'h0003) $display("FAIL control_readback got %h want 0003", rd);
    else passes++;
    bus_write(3'd5, 16'h0002);
    repeat (7) pulse(3, 2);
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 16'd7) $display("FAIL prescale_ticks got %h want 0007", rd);
    else passes++;
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 16'h0002) $display("FAIL prescale_time got %h want 0002", rd);
    else passes++;
    bus_write(3'd5, 16'h0002);
    repeat (2) pulse(3, 2);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 16'h0002) $display("FAIL pcount_zeroed got %h want 0002", rd);
    else passes++;
    pulse(3, 2);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 16'h0003) $display("FAIL pcount_third got %h want 0003", rd);
    else passes++;
    bus_write(3'd5, 16'h0000);
  endtask

  task automatic test_rollover();
    bus_write(3'd3, 16'h5958);
    repeat (2) pulse(3, 2);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 16'h0000) $display("FAIL wrap_time got %h want 0000", rd);
    else passes++;
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0006) $display("FAIL wrap_status got %h want 0006", rd);
    else passes++;
    bus_write(3'd0, 16'h0000);
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0002) $display("FAIL status_clear got %h want 0002", rd);
    else passes++;
    bus_write(3'd3, 16'h0059);
    pulse(3, 2);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 16'h0100) $display("FAIL min_carry got %h want 0100", rd);
    else passes++;
    checks++;
    if (irq !== 1'b1) $display("FAIL default_alarm_irq got %b want 1", irq);
    else passes++;
    bus_write(3'd0, 16'h0000);
    checks++;
    if (irq !== 1'b0) $display("FAIL irq_cleared got %b want 0", irq);
    else passes++;
    bus_write(3'd3, 16'h00FA);
    pulse(3, 2);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 16'h0100) $display("FAIL invalid_bcd got %h want 0100", rd);
    else passes++;
    bus_write(3'd0, 16'h0000);
    bus_write(3'd3, 16'h0959);
    pulse(3, 2);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 16'h1000) $display("FAIL ten_min_carry got %h want 1000", rd);
    else passes++;
  endtask

  task automatic test_alarm();
    bus_write(3'd1, 16'h0004);
    bus_write(3'd4, 16'h0003);
    bus_write(3'd1, 16'h000B);
    repeat (2) pulse(3, 2);
    tick_in = 1'b1;
    checks++;
    if (irq !== 1'b0) $display("FAIL irq_before_alarm got %b want 0", irq);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) $display("FAIL irq_after_alarm got %b want 1", irq);
    else passes++;
    @(negedge clk);
    pulse(2, 2);
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 16'h0009) $display("FAIL stop_on_alarm got %h want 0009", rd);
    else passes++;
    repeat (2) pulse(3, 2);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 16'h0003) $display("FAIL stopped_time got %h want 0003", rd);
    else passes++;
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 16'd3) $display("FAIL stopped_ticks got %h want 0003", rd);
    else passes++;
    bus_write(3'd0, 16'h0000);
    checks++;
    if (irq !== 1'b0) $display("FAIL status_write_irq got %b want 0", irq);
    else passes++;
  endtask

  task automatic test_back_to_back();
    bus_write(3'd3, 16'h0002);
    bus_write(3'd1, 16'h000B);
    tick_in = 1'b1;
    bus_write(3'd0, 16'h0000);
    checks++;
    if (irq !== 1'b1) $display("FAIL event_beats_status_write got %b want 1", irq);
    else passes++;
    tick_in = 1'b0;
    repeat (2) @(negedge clk);
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0001) $display("FAIL status_after_collision got %h want 0001", rd);
    else passes++;
    bus_write(3'd0, 16'h0000);
    bus_write(3'd1, 16'h0003);
    repeat (2) pulse(3, 2);
    tick_in = 1'b1;
    bus_write(3'd1, 16'h0007);
    pulse(2, 2);
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 16'h0000) $display("FAIL clear_vs_tick_ticks got %h want 0000", rd);
    else passes++;
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 16'h0000) $display("FAIL clear_vs_tick_time got %h want 0000", rd);
    else passes++;
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0002) $display("FAIL clear_keeps_status got %h want 0002", rd);
    else passes++;
  endtask

  task automatic test_async_reset();
    bus_write(3'd4, 16'h0001);
    pulse(3, 2);
    checks++;
    if (irq !== 1'b1) $display("FAIL pre_reset_irq got %b want 1", irq);
    else passes++;
    address = 3'd0;
    @(negedge clk);
    tick_in = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (readdata !== 16'h0000) $display("FAIL async_readdata got %h want 0000", readdata);
    else passes++;
    checks++;
    if (irq !== 1'b0) $display("FAIL async_irq got %b want 0", irq);
    else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_write(3'd1, 16'h0003);
    repeat (3) @(negedge clk);
    tick_in = 1'b0;
    @(negedge clk);
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 16'h0000) $display("FAIL no_event_after_reset got %h want 0000", rd);
    else passes++;
    bus_read(3'd4, rd);
    checks++;
    if (rd !== 16'h0100) $display("FAIL alarm_reset_value got %h want 0100", rd);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    reset_n = 1'b0;
    address = 3'd0;
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = 16'h0000;
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_count();
    test_prescale();
    test_rollover();
    test_alarm();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
